decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The block SHALL expose parameter NUM_DIGITS, default 4: number of multiplexed hex digits, legal range 1..8.
REQ-002 The block SHALL expose parameter SCAN_DIV, default 1024: clock cycles per digit slot, minimum 2.
REQ-003 The block SHALL expose parameter SEG_ACTIVE_LOW, default 0: 1 inverts seg_out and dig_en polarity.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  data_in holds a new display word.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 data_in  input  4*NUM_DIGITS  hex nibbles; nibble 0 is the least significant digit.
REQ-010 seg_out  output  7  segments, bit0=a .. bit6=g.
REQ-011 dig_en  output  NUM_DIGITS  one-hot digit enable.
REQ-012 frame_tick  output  1  one-cycle pulse when the scan index wraps to 0.

Function
REQ-013 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick = (count == SCAN_DIV-1).
REQ-014 On tick, the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-015 frame_tick SHALL be registered and high for exactly the cycle after the index wraps to 0.
REQ-016 A word SHALL be accepted on any edge where in_valid && in_ready; it goes into a pending register and sets pending_full.
REQ-017 in_ready SHALL equal !pending_full.
REQ-018 On an index wrap with pending_full set, the display register SHALL take the pending value and pending_full SHALL clear, so no frame ever shows a mixed word.
REQ-019 A word accepted on the same edge as a wrap SHALL stay pending until the following wrap.
REQ-020 seg_out and dig_en SHALL be registered from the current index and display register, giving one cycle of latency.
REQ-021 Hex encoding, active-high, listed a..g as bits g..a:
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
- 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
REQ-022 With SEG_ACTIVE_LOW=1, seg_out and dig_en SHALL be the bitwise inverse of the active-high values.

Reset
REQ-023 While rst_n is low, the following SHALL be held:
- prescaler = 0, index = 0, display = 0, pending discarded, pending_full = 0
- frame_tick = 0, in_ready = 0
- seg_out and dig_en inactive (all 0 active-high, all 1 active-low)
REQ-024 in_ready SHALL rise on the first edge after rst_n deasserts.
REQ-025 On that same first edge, outputs SHALL show digit 0 as "0".
REQ-026 Reset asserted mid-frame SHALL take effect immediately and discard any pending word.

Configuration
REQ-027 When DECODER_SCAN_BLANK_EN is defined, each zero-valued nibble above the most significant non-zero nibble SHALL drive all segments inactive; digit 0 is never blanked.
REQ-028 When DECODER_SCAN_BLANK_EN is not defined, every digit SHALL always be decoded.
REQ-029 dig_en scanning SHALL be unaffected by the macro.

Structure
REQ-030 Package decoder_pkg SHALL hold:
- the 16-entry segment encoding table
- the segment bit-index constants
- the nibble width constant (4)
REQ-031 Combinational sub-module hex_to_seg SHALL map a 4-bit nibble plus a blank flag to 7 active-high segments.
REQ-032 Polarity inversion SHALL be applied in decoder_scan only.

Verification (NUM_DIGITS=4, SCAN_DIV=4, SEG_ACTIVE_LOW=0 unless stated)
REQ-033 Reset then idle:
- first edge: dig_en=0001, seg_out=0111111
- dig_en steps 0010, 0100, 1000 every 4 cycles
- frame_tick pulses every 16 cycles
REQ-034 Load 0x1A3F mid-frame:
- in_ready falls next cycle
- after the next wrap, digits 0..3 show 1110001, 1001111, 1110111, 0000110
- in_ready rises on that wrap
REQ-035 Second word 0x2222 held valid while pending_full: it is not accepted until in_ready=1, then appears one frame later, never mixed with 0x1A3F in any frame.
REQ-036 Word accepted on the wrap edge: it displays only after the subsequent wrap, 16 cycles later.
REQ-037 With DECODER_SCAN_BLANK_EN, load 0x0070:
- digits 3 and 2 show 0000000
- digit 1 shows 0000111
- digit 0 shows 0111111
REQ-038 SEG_ACTIVE_LOW=1: rst_n pulsed low mid-frame gives seg_out=1111111, dig_en=1111, pending cleared; on release, digit 0 shows 1000000.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared constants for the decoder_scan display driver: nibble width,
// segment bit positions and the hex-to-segment table (bit6=g .. bit0=a).
package decoder_pkg;

  localparam int NIBBLE_W = 4;
  localparam int SEG_W    = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/decoder_scan_if.sv
// Load handshake between a producer of display words and decoder_scan.
interface decoder_scan_if
  import decoder_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic                           in_valid;
  logic                           in_ready;
  logic [NIBBLE_W*NUM_DIGITS-1:0] data_in;

  modport master (output in_valid, output data_in, input in_ready);
  modport slave  (input in_valid, input data_in, output in_ready);
endinterface

// File: rtl/decoder_scan_hex_to_seg.sv
// Combinational nibble-to-segment decoder, active-high, with a blank override.
module hex_to_seg
  import decoder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_nibble,
  input  logic                i_blank,
  output logic [SEG_W-1:0]    o_seg
);

  // Table lookup, forced dark when the digit is blanked
  always_comb begin
    o_seg = {SEG_W{1'b0}};
    if (i_blank) begin
      o_seg = {SEG_W{1'b0}};
    end else begin
      o_seg = SEG_TABLE[i_nibble];
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Multiplexed hex display scanner with frame-atomic word updates.
// Optional leading-zero blanking is enabled by defining DECODER_SCAN_BLANK_EN.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1024,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder_scan_if.slave         bus,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_tick
);

  localparam int                DATA_W   = NIBBLE_W * NUM_DIGITS;
  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic              POL      = 1'(SEG_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_W-1:0]     r_display;
  logic [DATA_W-1:0]     r_pending;
  logic                  r_pending_full;
  logic                  r_ready;
  logic                  r_frame_tick;
  logic [SEG_W-1:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_dig;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_accept;
  logic                  w_pending_full_nxt;
  logic [NIBBLE_W-1:0]   w_nibble;
  logic                  w_blank;
  logic [SEG_W-1:0]      w_seg;
  logic [NUM_DIGITS-1:0] w_dig_hi;

  assign w_tick   = (r_cnt == CNT_LAST);
  assign w_wrap   = w_tick && (r_idx == IDX_LAST);
  assign w_accept = bus.in_valid && r_ready;
  assign w_nibble = r_display[{r_idx, 2'b00} +: NIBBLE_W];
  assign w_dig_hi = NUM_DIGITS'(1'b1) << r_idx;

`ifdef DECODER_SCAN_BLANK_EN
  // Blank when this nibble and every nibble above it are zero; digit 0 always shows
  assign w_blank = (r_idx != {IDX_W{1'b0}}) &&
                   ((r_display >> {r_idx, 2'b00}) == {DATA_W{1'b0}});
`else
  assign w_blank = 1'b0;
`endif

  // Next pending_full: accept and frame swap are mutually exclusive
  always_comb begin
    w_pending_full_nxt = r_pending_full;
    if (w_accept) begin
      w_pending_full_nxt = 1'b1;
    end else if (w_wrap && r_pending_full) begin
      w_pending_full_nxt = 1'b0;
    end else begin
      w_pending_full_nxt = r_pending_full;
    end
  end

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
      r_idx <= {IDX_W{1'b0}};
    end else begin
      r_cnt <= w_tick ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
      if (w_tick) begin
        r_idx <= w_wrap ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
      end
    end
  end

  // Pending/display words; display only changes at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display      <= {DATA_W{1'b0}};
      r_pending      <= {DATA_W{1'b0}};
      r_pending_full <= 1'b0;
      r_ready        <= 1'b0;
    end else begin
      if (w_wrap && r_pending_full) begin
        r_display <= r_pending;
      end
      if (w_accept) begin
        r_pending <= bus.data_in;
      end
      r_pending_full <= w_pending_full_nxt;
      r_ready        <= ~w_pending_full_nxt;
    end
  end

  // Registered, polarity-adjusted display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= {SEG_W{POL}};
      r_dig        <= {NUM_DIGITS{POL}};
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= w_seg ^ {SEG_W{POL}};
      r_dig        <= w_dig_hi ^ {NUM_DIGITS{POL}};
      r_frame_tick <= w_wrap;
    end
  end

  assign bus.in_ready = r_ready;
  assign seg_out      = r_seg;
  assign dig_en       = r_dig;
  assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: active-high and active-low instances share stimulus.
module tb_decoder_scan;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       ft;
    logic       rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] seg_h, seg_l;
  logic [3:0] dig_h, dig_l;
  logic       ft_h, ft_l;

  decoder_scan_if #(.NUM_DIGITS(4)) bus_h ();
  decoder_scan_if #(.NUM_DIGITS(4)) bus_l ();

  decoder_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst_n(rst_n), .bus(bus_h),
    .seg_out(seg_h), .dig_en(dig_h), .frame_tick(ft_h)
  );

  decoder_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l),
    .seg_out(seg_l), .dig_en(dig_l), .frame_tick(ft_l)
  );

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  int          k;
  logic [15:0] m_disp;
  logic [15:0] m_pv;
  bit          m_pend;
  bit          m_acc;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int v);
    case (v)
      0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;  6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111; 10: return 7'b1110111; 11: return 7'b1111100;
      12: return 7'b0111001; 13: return 7'b1011110; 14: return 7'b1111001; 15: return 7'b1110001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] ref_digit(input logic [15:0] w, input int d);
    logic [15:0] up;
    up = w >> (4 * d);
`ifdef DECODER_SCAN_BLANK_EN
    if (d > 0 && up == 16'h0000) return 7'b0000000;
`endif
    return ref_seg(int'(up[3:0]));
  endfunction

  // One clock edge: k counts edges since reset release; a frame is 16 edges
  task automatic step(input logic v, input logic [15:0] d);
    exp_t e;
    bit   rdy_before;
    bit   wrap;
    int   idx_out;
    bus_h.in_valid = v; bus_h.data_in = d;
    bus_l.in_valid = v; bus_l.data_in = d;
    @(posedge clk);
    k++;
    rdy_before = (k > 1) && !m_pend;
    wrap       = (k % 16 == 0);
    idx_out    = ((k - 1) / 4) % 4;
    e.dig = 4'(1 << idx_out);
    e.seg = ref_digit(m_disp, idx_out);
    if (wrap && m_pend) begin
      m_disp = m_pv;
      m_pend = 1'b0;
    end
    m_acc = v && rdy_before;
    if (m_acc) begin
      m_pv   = d;
      m_pend = 1'b1;
    end
    e.ft  = wrap;
    e.rdy = !m_pend;
    q.push_back(e);
    #1;
  endtask

  task automatic model_reset();
    k = 0; m_disp = 16'h0000; m_pv = 16'h0000; m_pend = 1'b0; m_acc = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg_h"}, {1'b0, seg_h}, 8'h00);
    chk({tag, "_dig_h"}, {4'h0, dig_h}, 8'h00);
    chk({tag, "_ft_h"},  {7'h00, ft_h}, 8'h00);
    chk({tag, "_rdy_h"}, {7'h00, bus_h.in_ready}, 8'h00);
    chk({tag, "_seg_l"}, {1'b0, seg_l}, 8'h7F);
    chk({tag, "_dig_l"}, {4'h0, dig_l}, 8'h0F);
    chk({tag, "_ft_l"},  {7'h00, ft_l}, 8'h00);
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("seg_h", {1'b0, seg_h}, {1'b0, e.seg});
      chk("dig_h", {4'h0, dig_h}, {4'h0, e.dig});
      chk("ft_h",  {7'h00, ft_h}, {7'h00, e.ft});
      chk("rdy_h", {7'h00, bus_h.in_ready}, {7'h00, e.rdy});
      chk("seg_l", {1'b0, seg_l}, {1'b0, ~e.seg});
      chk("dig_l", {4'h0, dig_l}, {4'h0, ~e.dig});
      chk("ft_l",  {7'h00, ft_l}, {7'h00, e.ft});
      chk("rdy_l", {7'h00, bus_l.in_ready}, {7'h00, e.rdy});
    end
  end

  initial begin
    logic [15:0] d;
    logic [15:0] mask;
    bus_h.in_valid = 1'b0; bus_h.data_in = 16'h0000;
    bus_l.in_valid = 1'b0; bus_l.data_in = 16'h0000;
    model_reset();

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por_hold");
    @(negedge clk) rst_n = 1'b1;

    repeat (6) step(1'b0, 16'h0000);
    step(1'b1, 16'h1A3F);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 16'h2222);
      if (m_acc) break;
    end
    repeat (40) step(1'b0, 16'h0000);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 16'h0070);
      if (m_acc) break;
    end
    repeat (40) step(1'b0, 16'h0000);

    // Word accepted exactly on a wrap edge stays pending for a whole frame
    while ((k + 1) % 16 != 0) step(1'b0, 16'h0000);
    step(1'b1, 16'hBEEF);
    repeat (34) step(1'b0, 16'h0000);

    // Mid-frame reset with a word pending
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 16'h9C5D);
      if (m_acc) break;
    end
    step(1'b0, 16'h0000);
    rst_n = 1'b0;
    q.delete();
    #1 check_reset_outputs("mid");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("mid_hold");
    @(negedge clk) begin
      rst_n = 1'b1;
      model_reset();
    end

    for (int i = 0; i < 600; i++) begin
      case ($urandom % 4)
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      d = 16'($urandom) & mask;
      step(($urandom % 3) == 0, d);
    end
    step(1'b0, 16'h0000);

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
